usb_tx_packet_ctrl: RTL
=======================

// Module: usb_tx_packet_ctrl
// PURPOSE
//  Sequences one USB transmit packet by driving the per-field *_transmitting enables of t_timer
//  (SYNC -> PID -> DATA x N -> CRC16 -> EOP) and consuming its *_bits_transmitted pulses.
//  Sits between the TX host interface/FIFO and the t_timer + field shifters; owns EOP timing,
//  data-chunk fetch, abort and watchdog error handling. One packet in flight at a time.
// PARAMETERS
//  CLKS_PER_BIT   8      clocks per USB bit time (matches t_timer rollover_val)
//  MAX_CHUNKS     8      max 64-bit data chunks per packet (chunk_count width = $clog2(MAX_CHUNKS+1))
//  TIMEOUT_CLKS   2048   max clocks in one field phase before watchdog error
// PORTS
//  clk                 in   1   system clock
//  n_rst               in   1   asynchronous active-low reset
//  tx_start            in   1   request packet; sampled only in IDLE
//  pkt_type            in   1   0 = HANDSHAKE (no data/CRC), 1 = DATA packet
//  chunk_count         in   CW  64-bit chunks for DATA packet; 0 = zero-length packet; latched on start
//  tx_abort            in   1   abort current packet
//  fifo_empty          in   1   TX FIFO has no 64-bit chunk available
//  sync_bits_transmitted, pid_bits_transmitted, data_bits_transmitted, crc16_bits_transmitted  in 1 each  t_timer done pulses
//  sync_transmitting, pid_transmitting, data_transmitting, crc16_transmitting  out 1 each  t_timer phase enables (one-hot or all 0)
//  crc5_transmitting   out  1   tied 0 (token packets out of scope)
//  chunk_load          out  1   1-clk pulse: load next 64-bit chunk into data shifter
//  crc16_clear         out  1   1-clk pulse at packet start: reset CRC16 generator
//  eop_se0             out  1   drive SE0 on bus
//  eop_j               out  1   drive idle-J after SE0
//  tx_busy             out  1   high from start accept until DONE exits
//  tx_done             out  1   1-clk pulse: packet finished (success or error)
//  tx_error            out  1   qualifies tx_done: abort, FIFO underrun or watchdog
// BEHAVIOUR
//  - Reset: state IDLE; every output 0; chunk/bit/watchdog counters 0.
//  - States: IDLE, SYNC, PID, LOAD, DATA, CRC16, EOP_SE0, EOP_J, DONE.
//  - IDLE: tx_start=1 -> latch pkt_type/chunk_count, pulse crc16_clear, next cycle SYNC, tx_busy=1.
//  - Phase output = registered decode of state; each phase exits on the clock its done pulse is
//    seen; next enable high the following cycle. Done pulses for inactive phases are ignored.
//  - SYNC -> PID. PID -> EOP_SE0 if HANDSHAKE; -> CRC16 if DATA with chunk_count=0; else LOAD.
//  - LOAD (1 clk): fifo_empty=0 -> chunk_load pulse, -> DATA; fifo_empty=1 -> error, -> EOP_SE0.
//  - DATA: on data_bits_transmitted, remaining-1; remaining>0 -> LOAD, else -> CRC16.
//    data_transmitting drops for the LOAD cycle between chunks (clears t_timer receive counter).
//  - CRC16 -> EOP_SE0.
//  - EOP_SE0: eop_se0=1 for exactly 2*CLKS_PER_BIT clks; EOP_J: eop_j=1 for CLKS_PER_BIT clks.
//  - DONE (1 clk): tx_done=1, tx_error = sticky error flag; tx_busy=0 from next cycle; -> IDLE.
//  - tx_abort in SYNC/PID/LOAD/DATA/CRC16: set error, all phase enables 0 next cycle, -> EOP_SE0.
//    tx_abort in EOP_*/DONE/IDLE ignored. Abort same cycle as a done pulse: abort wins.
//  - Watchdog: counts clks in any field phase, clears on phase change; reaching TIMEOUT_CLKS ->
//    error, -> EOP_SE0.
//  - tx_start while busy ignored (not queued). Back-to-back: start in IDLE cycle after DONE accepted.
//  - Reset mid-packet: immediate return to reset values; no EOP driven.
//  - Invariant: at most one of the *_transmitting/eop_* outputs high in any cycle.
// STRUCTURE
//  - usb_tx_pkg: typedef enum tx_state_t, typedef enum pkt_type_t, EOP_SE0_BITS=2, EOP_J_BITS=1.
//  - Registered FSM + output decode; bit-time and watchdog counters reuse flex_counter
//    (rollover_val = CLKS_PER_BIT and TIMEOUT_CLKS); no new sub-module.
// TESTING
//  - HANDSHAKE: start, pulse sync then pid done -> sync,pid enables in order, SE0 16 clks, J 8 clks,
//    tx_done=1 tx_error=0, no data/crc16 enable ever.
//  - DATA chunk_count=2, fifo never empty -> 2 chunk_load pulses, data_transmitting low 1 clk between
//    chunks, crc16 phase, EOP, clean done.
//  - DATA chunk_count=0 -> PID then CRC16 directly; zero chunk_load pulses.
//  - fifo_empty=1 at 2nd LOAD -> DATA drops, EOP 24 clks, tx_done with tx_error=1.
//  - tx_abort in DATA coincident with data_bits_transmitted -> abort path, error done; no further
//    chunk_load. Withhold pid done 2048 clks -> watchdog error done.
//  - n_rst low mid-DATA -> all outputs 0 same edge; next tx_start runs a clean packet.

Source files
------------

// File: rtl/usb_tx_pkg.sv
// Shared types and constants for the USB transmit packet controller.
package usb_tx_pkg;

  typedef enum logic [3:0] {
    ST_IDLE,
    ST_SYNC,
    ST_PID,
    ST_LOAD,
    ST_DATA,
    ST_CRC16,
    ST_EOP_SE0,
    ST_EOP_J,
    ST_DONE
  } tx_state_t;

  typedef enum logic {
    PKT_HANDSHAKE = 1'b0,
    PKT_DATA      = 1'b1
  } pkt_type_t;

  localparam int unsigned EOP_SE0_BITS = 2;
  localparam int unsigned EOP_J_BITS   = 1;

  // Field phases are the states where abort and the watchdog apply.
  function automatic logic is_field(input tx_state_t s);
    return s inside {ST_SYNC, ST_PID, ST_LOAD, ST_DATA, ST_CRC16};
  endfunction

endpackage

// File: rtl/flex_counter.sv
// Up-counter with programmable rollover; counts 1..rollover_val while enabled.
module flex_counter #(
  parameter int unsigned NUM_CNT_BITS = 4
) (
  input  logic                    clk,
  input  logic                    n_rst,
  input  logic                    clear,
  input  logic                    count_enable,
  input  logic [NUM_CNT_BITS-1:0] rollover_val,
  output logic [NUM_CNT_BITS-1:0] count_out
);

  logic [NUM_CNT_BITS-1:0] count_q, count_d;

  // clear together with count_enable restarts at 1, so the first enabled cycle already counts.
  always_comb begin
    count_d = count_q;
    if (clear) begin
      count_d = count_enable ? NUM_CNT_BITS'(1) : '0;
    end else if (count_enable) begin
      count_d = (count_q == rollover_val) ? NUM_CNT_BITS'(1) : count_q + NUM_CNT_BITS'(1);
    end
  end

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) count_q <= '0;
    else        count_q <= count_d;
  end

  assign count_out = count_q;

endmodule

// File: rtl/usb_tx_packet_ctrl.sv
// Sequences one USB TX packet (SYNC, PID, DATA chunks, CRC16, EOP) by driving
// the t_timer phase enables and consuming its done pulses.
module usb_tx_packet_ctrl
  import usb_tx_pkg::*;
#(
  parameter  int unsigned CLKS_PER_BIT = 8,
  parameter  int unsigned MAX_CHUNKS   = 8,
  parameter  int unsigned TIMEOUT_CLKS = 2048,
  localparam int unsigned CW           = $clog2(MAX_CHUNKS + 1)
) (
  input  logic          clk,
  input  logic          n_rst,
  input  logic          tx_start,
  input  logic          pkt_type,
  input  logic [CW-1:0] chunk_count,
  input  logic          tx_abort,
  input  logic          fifo_empty,
  input  logic          sync_bits_transmitted,
  input  logic          pid_bits_transmitted,
  input  logic          data_bits_transmitted,
  input  logic          crc16_bits_transmitted,
  output logic          sync_transmitting,
  output logic          pid_transmitting,
  output logic          data_transmitting,
  output logic          crc16_transmitting,
  output logic          crc5_transmitting,
  output logic          chunk_load,
  output logic          crc16_clear,
  output logic          eop_se0,
  output logic          eop_j,
  output logic          tx_busy,
  output logic          tx_done,
  output logic          tx_error
);

  localparam int unsigned BW = $clog2(CLKS_PER_BIT + 1);
  localparam int unsigned WW = $clog2(TIMEOUT_CLKS + 1);

  tx_state_t     state_q, state_d;
  pkt_type_t     ptype_q, ptype_d;
  logic [CW-1:0] rem_q, rem_d;
  logic          err_q, err_d;
  logic [1:0]    eop_bits_q, eop_bits_d;

  logic [BW-1:0] bit_cnt;
  logic [WW-1:0] wd_cnt;
  logic          bit_tick, wd_tick;
  logic          eop_now, eop_next, bit_clear, wd_clear, wd_en;

  // Counters are steered by the next state so a phase's first cycle already counts as 1.
  assign eop_now   = state_q inside {ST_EOP_SE0, ST_EOP_J};
  assign eop_next  = state_d inside {ST_EOP_SE0, ST_EOP_J};
  assign bit_clear = !eop_now || !eop_next;
  assign wd_en     = is_field(state_d);
  assign wd_clear  = (state_d != state_q);
  assign bit_tick  = (bit_cnt == BW'(CLKS_PER_BIT));
  assign wd_tick   = (wd_cnt == WW'(TIMEOUT_CLKS));

  flex_counter #(.NUM_CNT_BITS(BW)) u_bit_cnt (
    .clk          (clk),
    .n_rst        (n_rst),
    .clear        (bit_clear),
    .count_enable (eop_next),
    .rollover_val (BW'(CLKS_PER_BIT)),
    .count_out    (bit_cnt)
  );

  flex_counter #(.NUM_CNT_BITS(WW)) u_wd_cnt (
    .clk          (clk),
    .n_rst        (n_rst),
    .clear        (wd_clear),
    .count_enable (wd_en),
    .rollover_val (WW'(TIMEOUT_CLKS)),
    .count_out    (wd_cnt)
  );

  always_comb begin
    state_d    = state_q;
    ptype_d    = ptype_q;
    rem_d      = rem_q;
    err_d      = err_q;
    eop_bits_d = eop_bits_q;
    case (state_q)
      ST_IDLE: if (tx_start) begin
        state_d = ST_SYNC;
        ptype_d = pkt_type_t'(pkt_type);
        rem_d   = chunk_count;
        err_d   = 1'b0;
      end
      ST_SYNC: if (sync_bits_transmitted) state_d = ST_PID;
      ST_PID: if (pid_bits_transmitted) begin
        if (ptype_q == PKT_HANDSHAKE) state_d = ST_EOP_SE0;
        else if (rem_q == '0)         state_d = ST_CRC16;
        else                          state_d = ST_LOAD;
      end
      ST_LOAD: begin
        if (fifo_empty) begin
          err_d   = 1'b1;
          state_d = ST_EOP_SE0;
        end else begin
          state_d = ST_DATA;
        end
      end
      ST_DATA: if (data_bits_transmitted) begin
        rem_d   = rem_q - CW'(1);
        state_d = (rem_q > CW'(1)) ? ST_LOAD : ST_CRC16;
      end
      ST_CRC16: if (crc16_bits_transmitted) state_d = ST_EOP_SE0;
      ST_EOP_SE0: if (bit_tick) begin
        if (eop_bits_q == 2'(EOP_SE0_BITS - 1)) begin
          eop_bits_d = '0;
          state_d    = ST_EOP_J;
        end else begin
          eop_bits_d = eop_bits_q + 2'd1;
        end
      end
      ST_EOP_J: if (bit_tick) begin
        if (eop_bits_q == 2'(EOP_J_BITS - 1)) begin
          eop_bits_d = '0;
          state_d    = ST_DONE;
        end else begin
          eop_bits_d = eop_bits_q + 2'd1;
        end
      end
      ST_DONE: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
    // Abort and watchdog override any done pulse seen in the same cycle.
    if (is_field(state_q) && (tx_abort || wd_tick)) begin
      err_d   = 1'b1;
      rem_d   = rem_q;
      state_d = ST_EOP_SE0;
    end
  end

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      state_q            <= ST_IDLE;
      ptype_q            <= PKT_HANDSHAKE;
      rem_q              <= '0;
      err_q              <= 1'b0;
      eop_bits_q         <= '0;
      sync_transmitting  <= 1'b0;
      pid_transmitting   <= 1'b0;
      data_transmitting  <= 1'b0;
      crc16_transmitting <= 1'b0;
      chunk_load         <= 1'b0;
      crc16_clear        <= 1'b0;
      eop_se0            <= 1'b0;
      eop_j              <= 1'b0;
      tx_busy            <= 1'b0;
      tx_done            <= 1'b0;
      tx_error           <= 1'b0;
    end else begin
      state_q            <= state_d;
      ptype_q            <= ptype_d;
      rem_q              <= rem_d;
      err_q              <= err_d;
      eop_bits_q         <= eop_bits_d;
      sync_transmitting  <= (state_d == ST_SYNC);
      pid_transmitting   <= (state_d == ST_PID);
      data_transmitting  <= (state_d == ST_DATA);
      crc16_transmitting <= (state_d == ST_CRC16);
      chunk_load         <= (state_q == ST_LOAD) && (state_d == ST_DATA);
      crc16_clear        <= (state_q == ST_IDLE) && (state_d == ST_SYNC);
      eop_se0            <= (state_d == ST_EOP_SE0);
      eop_j              <= (state_d == ST_EOP_J);
      tx_busy            <= (state_d != ST_IDLE);
      tx_done            <= (state_d == ST_DONE);
      tx_error           <= (state_d == ST_DONE) && err_d;
    end
  end

  assign crc5_transmitting = 1'b0;

endmodule
